wb2ahb_burst_bridge: RTL and testbench
======================================

Name: wb2ahb_burst_bridge

Overview:
- Parametrised Wishbone B3 master-side to AHB-Lite master bridge; next generation of the fabric's WB-to-AHB bridge.
- Adds configurable data/address width, byte/halfword sizing from `wb_sel_i`, pipelined incrementing and wrapping bursts (CTI/BTE), 1 KB boundary splitting and two-cycle AHB ERROR handling.
- Sits between a Wishbone master (CPU-side or DMA) and the AHB-Lite interconnect.
- Single master: no bus request or grant.

Parameters:
- ADDR_WIDTH, 32, width of `wb_adr_i` and `HADDR`.
- DATA_WIDTH, 32, data width; legal values are 32 or 64. NB = DATA_WIDTH/8 and LB = log2(NB).
- HPROT_VAL, 4'b0011, constant driven on `HPROT` (non-cacheable, privileged data).

Ports:
- HCLK  in  1  clock; all logic is on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- wb_adr_i  in  ADDR_WIDTH  byte address; bits [LB-1:0] are ignored.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_sel_i  in  NB  byte lane selects.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_dat_o  out  DATA_WIDTH  read data, equal to `HRDATA`.
- wb_ack_o  out  1  beat complete.
- wb_err_o  out  1  beat error.
- HADDR  out  ADDR_WIDTH  AHB address.
- HTRANS  out  2  AHB transfer type: IDLE 00, NONSEQ 10, SEQ 11.
- HWRITE  out  1  AHB write.
- HSIZE  out  3  AHB transfer size.
- HBURST  out  3  AHB burst type.
- HPROT  out  4  AHB protection; driven to HPROT_VAL.
- HWDATA  out  DATA_WIDTH  write data, equal to `wb_dat_i`.
- HRDATA  in  DATA_WIDTH  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  1  AHB response: 0 OKAY, 1 ERROR.

Behaviour:

States:
- IDLE: no data phase pending.
- DPH: data phase, no address pending.
- BDPH: data phase with the next SEQ address driven.
- ERR2: second cycle of an ERROR response.
- SELERR: illegal byte-lane request.

Reset:
- State is IDLE.
- `HTRANS` = IDLE; `wb_ack_o` = `wb_err_o` = 0.
- Address, control and beat counter registers are 0.
- HRESET mid-transfer forces IDLE in the next cycle; any AHB data phase in progress is abandoned.

Address phase:
- In IDLE, `wb_cyc_i` & `wb_stb_i` & legal request: drive NONSEQ combinationally from the WB inputs.
- If HREADY=1 at the edge, the address is accepted. Go to BDPH if `wb_cti_i`=010, otherwise go to DPH.
- The address and control used for each beat are registered.

Sizing:
- Legal `wb_sel_i` pattern: contiguous ones, popcount k a power of two, lowest set lane index a multiple of k.
- Legal request: HSIZE = log2(k); `HADDR`[LB-1:0] = lowest set lane index.
- Illegal pattern: no AHB transfer. Go to SELERR; `wb_err_o` = 1 for one cycle; return to IDLE.
- Bursts (`wb_cti_i`=010) always use full width: HSIZE = LB and `wb_sel_i` is ignored.

HBURST:
- SINGLE (000) when `wb_cti_i` ≠ 010.
- With `wb_cti_i` = 010, `wb_bte_i` 00 → INCR (001), 01 → WRAP4 (010), 10 → WRAP8 (100), 11 → WRAP16 (110).

Data phase (DPH or BDPH):
- `wb_ack_o` = HREADY & ~HRESP; `wb_dat_o` = `HRDATA`; `HWDATA` = `wb_dat_i`.
- Zero-wait single transfer: NONSEQ in cycle 0, ack in cycle 1.

Pipelined burst (BDPH):
- While beat n is in its data phase, drive beat n+1's address with SEQ.
- Beat n+1's address = previous address + NB, with the low bits wrapped under mask (beats*NB - 1) for WRAPx.
- When HREADY=1 and the current beat has `wb_cti_i`=010: stay in BDPH.
- When HREADY=1 and the current beat has `wb_cti_i`=111 or 000: HTRANS=IDLE, no further address; go to DPH, or to IDLE if no beat is pending.
- Linear burst whose next address crosses a 1 KB boundary (`addr`[9:0] wraps to 0): that beat is issued as NONSEQ with HBURST=INCR instead of SEQ. WRAP bursts never cross the boundary.

Wishbone master constraints:
- `wb_stb_i` and `wb_cyc_i` stay high from the first beat to the final ack of a burst. A mid-burst drop is unsupported.
- After the final ack of a transfer, the bridge returns to IDLE and may accept a new NONSEQ in the next cycle.

ERROR response:
- First cycle (HRESP=1, HREADY=0): HTRANS is forced to IDLE in that same cycle, cancelling any pending SEQ; go to ERR2.
- ERR2 (HRESP=1, HREADY=1): `wb_err_o`=1, `wb_ack_o`=0; the burst is terminated; go to IDLE.
- `wb_ack_o` and `wb_err_o` are never asserted together.

Test Plan:
1. Single 32-bit read, `wb_adr_i`=0x1000, sel=1111, zero wait → NONSEQ HADDR=0x1000 HSIZE=010 HBURST=000 in cycle 0; ack in cycle 1 with `wb_dat_o`=`HRDATA`=0xDEADBEEF.
2. Byte write, `wb_adr_i`=0x2000, sel=0100, data 0x00AB0000 → HADDR=0x2002, HSIZE=000, HWDATA=0x00AB0000; one ack. With sel=0110: `wb_err_o` for one cycle, HTRANS remains IDLE.
3. INCR write of 4 beats from 0x3000, cti 010,010,010,111, zero wait → HTRANS NONSEQ,SEQ,SEQ,SEQ,IDLE; HADDR 0x3000,0x3004,0x3008,0x300C; 4 acks in consecutive cycles; HWDATA matches each beat.
4. WRAP4 read from 0x400C (bte=01) → HBURST=010; HADDR 0x400C,0x4000,0x4004,0x4008; 4 acks.
5. INCR burst from 0x13F8 → third beat at 0x1400 issued as NONSEQ; beat 2 address 0x13FC is SEQ.
6. ERROR: slave returns ERROR on beat 2 of an 8-beat INCR → HTRANS=IDLE during the HREADY=0 cycle; `wb_err_o`=1 in the next cycle; no further beats; bridge idle. Plus one run with DATA_WIDTH=64: burst address step 8, HSIZE=011.

Source files
------------

// File: rtl/wb2ahb_burst_bridge.sv
// Wishbone B3 master-side to AHB-Lite master bridge: lane-sized singles, pipelined
// INCR/WRAP bursts from CTI/BTE, 1 KB boundary re-NONSEQ and two-cycle ERROR handling.
module wb2ahb_burst_bridge #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic                    wb_we_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic [2:0]              wb_cti_i,
    input  logic [1:0]              wb_bte_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic [ADDR_WIDTH-1:0]   HADDR,
    output logic [1:0]              HTRANS,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [3:0]              HPROT,
    output logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic [DATA_WIDTH-1:0]   HRDATA,
    input  logic                    HREADY,
    input  logic                    HRESP
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR   = 3'b001;
    localparam logic [2:0] HB_WRAP4  = 3'b010;
    localparam logic [2:0] HB_WRAP8  = 3'b100;
    localparam logic [2:0] HB_WRAP16 = 3'b110;
    localparam logic [2:0] CTI_INCR  = 3'b010;

    typedef enum logic [2:0] {ST_IDLE, ST_DPH, ST_BDPH, ST_ERR2, ST_SELERR} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   haddr_q, haddr_d;
    logic [2:0]              hsize_q, hsize_d;
    logic [2:0]              hburst_q, hburst_d;
    logic                    hwrite_q, hwrite_d;

    logic                    sel_legal;
    logic [2:0]              sel_size;
    logic [LB-1:0]           sel_lo;
    logic                    is_burst;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [2:0]              req_size;
    logic [2:0]              req_burst;
    logic [ADDR_WIDTH-1:0]   nxt_addr;
    logic                    nxt_cross;
    logic                    unused_adr_lsb;

    function automatic logic [ADDR_WIDTH-1:0] next_beat_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                             input logic [2:0]            burst);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc = addr + ADDR_WIDTH'(NB);
        case (burst)
            HB_WRAP4:  mask = ADDR_WIDTH'(4 * NB - 1);
            HB_WRAP8:  mask = ADDR_WIDTH'(8 * NB - 1);
            HB_WRAP16: mask = ADDR_WIDTH'(16 * NB - 1);
            default:   mask = '1;
        endcase
        return (addr & ~mask) | (inc & mask);
    endfunction

    // A lane pattern is legal when it is one naturally aligned power-of-two run of ones.
    always_comb begin : sel_decode
        int            cnt;
        int            lo;
        logic [NB-1:0] run;
        cnt = 0;
        lo  = 0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (wb_sel_i[i]) begin
                cnt = cnt + 1;
                lo  = i;
            end
        end
        run       = NB'(((1 << cnt) - 1) << lo);
        sel_legal = (cnt != 0) && ((cnt & (cnt - 1)) == 0) && ((lo & (cnt - 1)) == 0)
                    && (run == wb_sel_i);
        case (cnt)
            2:       sel_size = 3'd1;
            4:       sel_size = 3'd2;
            8:       sel_size = 3'd3;
            default: sel_size = 3'd0;
        endcase
        sel_lo = LB'(lo);
    end

    assign is_burst  = (wb_cti_i == CTI_INCR);
    assign req_addr  = is_burst ? {wb_adr_i[ADDR_WIDTH-1:LB], {LB{1'b0}}}
                                : {wb_adr_i[ADDR_WIDTH-1:LB], sel_lo};
    assign req_size  = is_burst ? 3'(LB) : sel_size;
    assign nxt_addr  = next_beat_addr(haddr_q, hburst_q);
    assign nxt_cross = (hburst_q == HB_INCR) && (nxt_addr[9:0] == 10'd0);

    always_comb begin
        req_burst = HB_SINGLE;
        if (is_burst) begin
            case (wb_bte_i)
                2'b00:   req_burst = HB_INCR;
                2'b01:   req_burst = HB_WRAP4;
                2'b10:   req_burst = HB_WRAP8;
                default: req_burst = HB_WRAP16;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        hsize_d  = hsize_q;
        hburst_d = hburst_q;
        hwrite_d = hwrite_q;
        HTRANS   = TR_IDLE;
        HADDR    = haddr_q;
        HWRITE   = hwrite_q;
        HSIZE    = hsize_q;
        HBURST   = hburst_q;
        wb_ack_o = 1'b0;
        wb_err_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i && !HRESET) begin
                    if (is_burst || sel_legal) begin
                        HTRANS = TR_NONSEQ;
                        HADDR  = req_addr;
                        HWRITE = wb_we_i;
                        HSIZE  = req_size;
                        HBURST = req_burst;
                        if (HREADY) begin
                            haddr_d  = req_addr;
                            hsize_d  = req_size;
                            hburst_d = req_burst;
                            hwrite_d = wb_we_i;
                            state_d  = is_burst ? ST_BDPH : ST_DPH;
                        end
                    end else begin
                        state_d = ST_SELERR;
                    end
                end
            end
            ST_DPH, ST_BDPH: begin
                wb_ack_o = HREADY & ~HRESP;
                // ERROR cancels any pending SEQ; HTRANS stays IDLE from the default.
                if (HRESP) begin
                    wb_err_o = HREADY;
                    state_d  = HREADY ? ST_IDLE : ST_ERR2;
                end else if (state_q == ST_BDPH && wb_cti_i == CTI_INCR) begin
                    HTRANS = nxt_cross ? TR_NONSEQ : TR_SEQ;
                    HADDR  = nxt_addr;
                    if (HREADY) begin
                        haddr_d = nxt_addr;
                    end
                end else if (HREADY) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR2: begin
                wb_err_o = HREADY;
                if (HREADY) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SELERR: begin
                wb_err_o = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            haddr_q  <= '0;
            hsize_q  <= '0;
            hburst_q <= '0;
            hwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hsize_q  <= hsize_d;
            hburst_q <= hburst_d;
            hwrite_q <= hwrite_d;
        end
    end

    assign wb_dat_o       = HRDATA;
    assign HWDATA         = wb_dat_i;
    assign HPROT          = HPROT_VAL;
    assign unused_adr_lsb = ^wb_adr_i[LB-1:0];

endmodule

// File: tb/tb_wb2ahb_burst_bridge.sv
// Self-checking bench for wb2ahb_burst_bridge: a Wishbone master driver, an AHB slave
// with a deterministic data pattern, and expected beats computed from the bus rules.
module tb_wb2ahb_burst_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0] wb_adr, wb_dat_w, wb_dat_r, haddr, hwdata, hrdata;
    logic [3:0]  wb_sel, hprot;
    logic [2:0]  wb_cti, hsize, hburst;
    logic [1:0]  wb_bte, htrans;
    logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err, hwrite, hready, hresp;

    logic [31:0] w_adr, h64_addr;
    logic [63:0] w_dat_w, w_dat_r, h64_wdata, h64_rdata;
    logic [7:0]  w_sel;
    logic [3:0]  h64_prot;
    logic [2:0]  w_cti, h64_size, h64_burst;
    logic [1:0]  w_bte, h64_trans;
    logic        w_we, w_cyc, w_stb, w_ack, w_err, h64_write, h64_ready, h64_resp;

    wb2ahb_burst_bridge dut (
        .HCLK(clk), .HRESET(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_sel_i(wb_sel),
        .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_cti_i(wb_cti),
        .wb_bte_i(wb_bte), .wb_dat_o(wb_dat_r), .wb_ack_o(wb_ack), .wb_err_o(wb_err),
        .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HWDATA(hwdata), .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp)
    );

    wb2ahb_burst_bridge #(.DATA_WIDTH(64)) dut64 (
        .HCLK(clk), .HRESET(rst), .wb_adr_i(w_adr), .wb_dat_i(w_dat_w), .wb_sel_i(w_sel),
        .wb_we_i(w_we), .wb_cyc_i(w_cyc), .wb_stb_i(w_stb), .wb_cti_i(w_cti),
        .wb_bte_i(w_bte), .wb_dat_o(w_dat_r), .wb_ack_o(w_ack), .wb_err_o(w_err),
        .HADDR(h64_addr), .HTRANS(h64_trans), .HWRITE(h64_write), .HSIZE(h64_size),
        .HBURST(h64_burst), .HPROT(h64_prot), .HWDATA(h64_wdata), .HRDATA(h64_rdata),
        .HREADY(h64_ready), .HRESP(h64_resp)
    );

    int checks = 0;
    int failures = 0;

    // Observations collected by the driver, compared by each scenario task.
    logic [31:0] rec_addr[$];
    logic [1:0]  rec_trans[$];
    logic [2:0]  rec_size[$];
    logic [2:0]  rec_burst[$];
    logic        rec_write[$];
    int          rec_cyc[$];
    logic [31:0] ack_dat[$];
    logic [31:0] ack_wdat[$];
    int          ack_cyc[$];
    int          err_cyc[$];
    logic [1:0]  trans_log[$];
    logic [1:0]  trans_err1[$];
    int          both_cnt;
    logic [31:0] wdata_tb[16];
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_rd = 32'h0;

    logic [2:0]  hb_tab[4] = '{3'b001, 3'b010, 3'b100, 3'b110};

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        if (use_fixed) return fixed_rd;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] start, input int b, input logic [1:0] bte);
        logic [31:0] a0, span, base;
        a0 = start & 32'hFFFF_FFFC;
        if (bte == 2'b00) return a0 + 32'(b * 4);
        span = 32'((2 << bte) * 4);
        base = a0 & ~(span - 32'd1);
        return base + ((a0 - base + 32'(b * 4)) % span);
    endfunction

    task automatic run_xfer(input logic [31:0] adr, input bit we, input int nbeats, input bit burst,
                            input logic [1:0] bte, input logic [3:0] sel, input int wait_pct,
                            input int err_beat);
        int b = 0, cyc = 0, acc = 0, dph_idx = 0, err_stage = 0;
        bit dph_v = 1'b0, done = 1'b0;
        logic [31:0] dph_a = '0;
        rec_addr.delete(); rec_trans.delete(); rec_size.delete(); rec_burst.delete();
        rec_write.delete(); rec_cyc.delete(); ack_dat.delete(); ack_wdat.delete();
        ack_cyc.delete(); err_cyc.delete(); trans_log.delete(); trans_err1.delete();
        both_cnt = 0;
        while (!done) begin
            wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_bte = bte;
            wb_adr = burst ? adr + 32'(b * 4) : adr;
            wb_cti = burst ? ((b == nbeats - 1) ? 3'b111 : 3'b010) : 3'b000;
            wb_dat_w = wdata_tb[b % 16];
            if (dph_v && dph_idx == err_beat) begin
                hresp = 1'b1; hready = (err_stage != 0); err_stage++;
            end else begin
                hresp = 1'b0; hready = !dph_v || ($urandom_range(99) >= 32'(wait_pct));
            end
            hrdata = dph_v ? slave_rd(dph_a) : $urandom;
            @(negedge clk);
            trans_log.push_back(htrans);
            if (hresp && !hready) trans_err1.push_back(htrans);
            if (wb_ack && wb_err) both_cnt++;
            if (hready && htrans[1]) begin
                rec_addr.push_back(haddr); rec_trans.push_back(htrans); rec_size.push_back(hsize);
                rec_burst.push_back(hburst); rec_write.push_back(hwrite); rec_cyc.push_back(cyc);
            end
            if (wb_ack) begin
                ack_dat.push_back(wb_dat_r); ack_wdat.push_back(hwdata); ack_cyc.push_back(cyc); b++;
            end
            if (wb_err) err_cyc.push_back(cyc);
            if (hready) begin
                dph_v = htrans[1]; dph_a = haddr;
                if (htrans[1]) begin dph_idx = acc; acc++; end
            end
            if (wb_err || b >= nbeats) done = 1'b1;
            cyc++;
            if (!done && cyc > 300) begin
                checks++; failures++;
                $display("FAIL timeout: acks=%0d required=%0d", b, nbeats);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_cti = 3'b000; hready = 1'b1; hresp = 1'b0;
    endtask

    task automatic test_reset();
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_cti = 3'b000; wb_sel = 4'hF; wb_adr = 32'h100;
        @(negedge clk);
        checks++;
        if (htrans !== 2'b00 || wb_ack !== 1'b0 || wb_err !== 1'b0 || hprot !== 4'b0011) begin
            failures++;
            $display("FAIL reset_outputs: htrans=%b ack=%b err=%b hprot=%b required 00 0 0 0011",
                     htrans, wb_ack, wb_err, hprot);
        end
        @(posedge clk); #1;
        rst = 1'b0; wb_cti = 3'b010; wb_adr = 32'h7000; hready = 1'b1; hresp = 1'b0;
        @(negedge clk);
        checks++;
        if (htrans !== 2'b10 || haddr !== 32'h7000) begin
            failures++; $display("FAIL reset_first_nonseq: htrans=%b haddr=%h required 10 7000", htrans, haddr);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (htrans !== 2'b00 || wb_ack !== 1'b0) begin
            failures++; $display("FAIL reset_mid_burst: htrans=%b ack=%b required 00 0", htrans, wb_ack);
        end
        @(posedge clk); #1;
        rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_cti = 3'b000;
        @(negedge clk);
        checks++;
        if (htrans !== 2'b00 || wb_ack !== 1'b0 || wb_err !== 1'b0) begin
            failures++; $display("FAIL reset_abandon: htrans=%b ack=%b err=%b required 00 0 0", htrans, wb_ack, wb_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        logic [3:0] sel_tab[7]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        logic [1:0] lo_tab[7]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0};
        logic [2:0] size_tab[7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
        use_fixed = 1'b1; fixed_rd = 32'hDEADBEEF;
        run_xfer(32'h1000, 1'b0, 1, 1'b0, 2'b00, 4'hF, 0, -1);
        use_fixed = 1'b0;
        checks++;
        if (rec_addr.size() != 1 || rec_addr[0] !== 32'h1000 || rec_trans[0] !== 2'b10 ||
            rec_size[0] !== 3'b010 || rec_burst[0] !== 3'b000 || rec_cyc[0] != 0) begin
            failures++;
            $display("FAIL single_addr_phase: n=%0d addr=%h trans=%b size=%b burst=%b required 1 1000 10 010 000",
                     rec_addr.size(), rec_addr[0], rec_trans[0], rec_size[0], rec_burst[0]);
        end
        checks++;
        if (ack_cyc.size() != 1 || ack_cyc[0] != 1 || ack_dat[0] !== 32'hDEADBEEF || trans_log[1] !== 2'b00) begin
            failures++;
            $display("FAIL single_ack: n=%0d cyc=%0d dat=%h required 1 1 deadbeef", ack_cyc.size(), ack_cyc[0], ack_dat[0]);
        end
        for (int t = 0; t < 8; t++) begin
            int k = $urandom_range(6);
            logic [31:0] a = $urandom;
            bit we = 1'($urandom_range(1));
            logic [31:0] ea = {a[31:2], lo_tab[k]};
            wdata_tb[0] = $urandom;
            run_xfer(a, we, 1, 1'b0, 2'b00, sel_tab[k], 40, -1);
            checks++;
            if (rec_addr.size() != 1 || ack_dat.size() != 1 || rec_addr[0] !== ea || rec_size[0] !== size_tab[k] ||
                rec_write[0] !== we || (!we && ack_dat[0] !== slave_rd(ea)) || (we && ack_wdat[0] !== wdata_tb[0])) begin
                failures++;
                $display("FAIL single_random sel=%b: addr=%h size=%b rdat=%h wdat=%h required addr=%h size=%b",
                         sel_tab[k], rec_addr[0], rec_size[0], ack_dat[0], ack_wdat[0], ea, size_tab[k]);
            end
        end
    endtask

    task automatic test_byte_write();
        logic [3:0] bad_tab[6] = '{4'b0110, 4'b0101, 4'b1010, 4'b1110, 4'b0111, 4'b0000};
        wdata_tb[0] = 32'h00AB0000;
        run_xfer(32'h2000, 1'b1, 1, 1'b0, 2'b00, 4'b0100, 0, -1);
        checks++;
        if (rec_addr.size() != 1 || rec_addr[0] !== 32'h2002 || rec_size[0] !== 3'b000 ||
            ack_cyc.size() != 1 || ack_wdat[0] !== 32'h00AB0000 || err_cyc.size() != 0) begin
            failures++;
            $display("FAIL byte_write: addr=%h size=%b acks=%0d hwdata=%h required 2002 000 1 00ab0000",
                     rec_addr[0], rec_size[0], ack_cyc.size(), ack_wdat[0]);
        end
        for (int t = 0; t < 6; t++) begin
            run_xfer(32'h2000, 1'b1, 1, 1'b0, 2'b00, bad_tab[t], 0, -1);
            checks++;
            if (rec_addr.size() != 0 || ack_cyc.size() != 0 || err_cyc.size() != 1 || err_cyc[0] != 1 ||
                trans_log[0] !== 2'b00) begin
                failures++;
                $display("FAIL sel_error sel=%b: addr_phases=%0d acks=%0d errs=%0d htrans=%b required 0 0 1 00",
                         bad_tab[t], rec_addr.size(), ack_cyc.size(), err_cyc.size(), trans_log[0]);
            end
        end
    endtask

    task automatic test_incr_write();
        for (int b = 0; b < 16; b++) wdata_tb[b] = $urandom;
        run_xfer(32'h3000, 1'b1, 4, 1'b1, 2'b00, 4'hF, 0, -1);
        checks++;
        if (rec_addr.size() != 4 || ack_cyc.size() != 4 || trans_log[4] !== 2'b00) begin
            failures++;
            $display("FAIL incr_counts: addr_phases=%0d acks=%0d htrans_end=%b required 4 4 00",
                     rec_addr.size(), ack_cyc.size(), trans_log[4]);
        end
        for (int b = 0; b < 4 && b < rec_addr.size() && b < ack_cyc.size(); b++) begin
            checks++;
            if (rec_addr[b] !== 32'h3000 + 32'(4 * b) || rec_trans[b] !== ((b == 0) ? 2'b10 : 2'b11) ||
                rec_burst[b] !== 3'b001 || rec_size[b] !== 3'b010 || rec_write[b] !== 1'b1 ||
                ack_cyc[b] != b + 1 || ack_wdat[b] !== wdata_tb[b]) begin
                failures++;
                $display("FAIL incr_beat%0d: addr=%h trans=%b burst=%b ackcyc=%0d hwdata=%h required addr=%h hwdata=%h",
                         b, rec_addr[b], rec_trans[b], rec_burst[b], ack_cyc[b], ack_wdat[b],
                         32'h3000 + 32'(4 * b), wdata_tb[b]);
            end
        end
    endtask

    task automatic test_wrap_read();
        run_xfer(32'h400C, 1'b0, 4, 1'b1, 2'b01, 4'hF, 0, -1);
        checks++;
        if (rec_addr.size() != 4 || ack_cyc.size() != 4) begin
            failures++; $display("FAIL wrap4_counts: addr_phases=%0d acks=%0d required 4 4", rec_addr.size(), ack_cyc.size());
        end
        for (int b = 0; b < 4 && b < rec_addr.size() && b < ack_dat.size(); b++) begin
            logic [31:0] ea = exp_addr(32'h400C, b, 2'b01);
            checks++;
            if (rec_addr[b] !== ea || rec_burst[b] !== 3'b010 || ack_dat[b] !== slave_rd(ea)) begin
                failures++;
                $display("FAIL wrap4_beat%0d: addr=%h burst=%b rdat=%h required %h 010 %h",
                         b, rec_addr[b], rec_burst[b], ack_dat[b], ea, slave_rd(ea));
            end
        end
    endtask

    task automatic test_boundary();
        run_xfer(32'h13F8, 1'b0, 4, 1'b1, 2'b00, 4'hF, 0, -1);
        checks++;
        if (rec_addr.size() != 4 || rec_addr[1] !== 32'h13FC || rec_trans[1] !== 2'b11 ||
            rec_addr[2] !== 32'h1400 || rec_trans[2] !== 2'b10 || rec_burst[2] !== 3'b001 || rec_trans[3] !== 2'b11) begin
            failures++;
            $display("FAIL boundary: beat1 %h/%b beat2 %h/%b beat3 %b required 13fc/11 1400/10 11",
                     rec_addr[1], rec_trans[1], rec_addr[2], rec_trans[2], rec_trans[3]);
        end
    endtask

    task automatic test_error();
        run_xfer(32'h6000, 1'b0, 8, 1'b1, 2'b00, 4'hF, 0, 2);
        checks++;
        if (rec_addr.size() != 3 || ack_cyc.size() != 2 || err_cyc.size() != 1 || trans_err1.size() != 1 ||
            trans_err1[0] !== 2'b00 || err_cyc[0] != 4 || both_cnt != 0) begin
            failures++;
            $display("FAIL error_burst: addr_phases=%0d acks=%0d errs=%0d htrans_err1=%b errcyc=%0d required 3 2 1 00 4",
                     rec_addr.size(), ack_cyc.size(), err_cyc.size(), trans_err1[0], err_cyc[0]);
        end
        @(negedge clk);
        checks++;
        if (htrans !== 2'b00 || wb_ack !== 1'b0 || wb_err !== 1'b0) begin
            failures++; $display("FAIL error_idle: htrans=%b ack=%b err=%b required 00 0 0", htrans, wb_ack, wb_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_bursts();
        for (int t = 0; t < 10; t++) begin
            logic [1:0]  bte = 2'($urandom_range(3));
            logic [31:0] st = {14'd0, 16'($urandom), 2'b00};
            bit          we = 1'($urandom_range(1));
            int          n = (bte == 2'b00) ? int'($urandom_range(2, 12)) : (2 << bte);
            int          bad = 0;
            for (int b = 0; b < 16; b++) wdata_tb[b] = $urandom;
            run_xfer(st, we, n, 1'b1, bte, 4'hF, 30, -1);
            checks++;
            if (rec_addr.size() != n || ack_cyc.size() != n || err_cyc.size() != 0 || both_cnt != 0) begin
                failures++;
                $display("FAIL rand_counts t=%0d: addr_phases=%0d acks=%0d errs=%0d required %0d %0d 0",
                         t, rec_addr.size(), ack_cyc.size(), err_cyc.size(), n, n);
            end
            for (int b = 0; b < n && b < rec_addr.size() && b < ack_dat.size(); b++) begin
                logic [31:0] ea = exp_addr(st, b, bte);
                logic [1:0]  et = (b == 0 || (bte == 2'b00 && ea[9:0] == 10'd0)) ? 2'b10 : 2'b11;
                if (rec_addr[b] !== ea || rec_trans[b] !== et || rec_burst[b] !== hb_tab[bte] ||
                    (!we && ack_dat[b] !== slave_rd(ea)) || (we && ack_wdat[b] !== wdata_tb[b])) begin
                    bad++;
                    if (bad == 1)
                        $display("FAIL rand_beat t=%0d b=%0d: addr=%h trans=%b burst=%b required %h %b %b",
                                 t, b, rec_addr[b], rec_trans[b], rec_burst[b], ea, et, hb_tab[bte]);
                end
            end
            checks++;
            if (bad != 0) failures++;
        end
    endtask

    task automatic test_back_to_back();
        wdata_tb[0] = 32'h1234_5678;
        run_xfer(32'h8000, 1'b1, 1, 1'b0, 2'b00, 4'hF, 0, -1);
        run_xfer(32'h9000, 1'b0, 3, 1'b1, 2'b00, 4'hF, 0, -1);
        checks++;
        if (rec_addr.size() != 3 || rec_cyc[0] != 0 || rec_addr[0] !== 32'h9000 ||
            ack_cyc.size() != 3 || ack_cyc[2] != 3 || ack_dat[2] !== slave_rd(32'h9008)) begin
            failures++;
            $display("FAIL back_to_back: first_cyc=%0d addr=%h acks=%0d rdat=%h required 0 9000 3 %h",
                     rec_cyc[0], rec_addr[0], ack_cyc.size(), ack_dat[2], slave_rd(32'h9008));
        end
    endtask

    task automatic test_wide64();
        w_cyc = 1'b1; w_stb = 1'b1; w_we = 1'b0; w_sel = 8'hFF; w_bte = 2'b00; w_adr = 32'h5000;
        h64_ready = 1'b1; h64_resp = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            int beat = (c == 0) ? 0 : c - 1;
            logic [31:0] ea = 32'h5000 + 32'(8 * c);
            logic [63:0] rd = {32'hCAFE0000 + 32'(beat), 32'h5000 + 32'(8 * beat)};
            w_cti = (beat == 3) ? 3'b111 : 3'b010;
            h64_rdata = rd;
            @(negedge clk);
            checks++;
            if ((c < 4 && (h64_trans[1] !== 1'b1 || h64_addr !== ea || h64_size !== 3'b011)) ||
                (c == 4 && h64_trans !== 2'b00) || (c >= 1 && (w_ack !== 1'b1 || w_dat_r !== rd)) ||
                (c == 0 && w_ack !== 1'b0)) begin
                failures++;
                $display("FAIL wide64 c=%0d: htrans=%b haddr=%h hsize=%b ack=%b required addr=%h size=011",
                         c, h64_trans, h64_addr, h64_size, w_ack, ea);
            end
            @(posedge clk); #1;
        end
        w_cyc = 1'b0; w_stb = 1'b0; w_cti = 3'b000;
    endtask

    initial begin
        rst = 1'b1;
        wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        wb_cti = '0; wb_bte = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        w_adr = '0; w_dat_w = '0; w_sel = '0; w_we = 1'b0; w_cyc = 1'b0; w_stb = 1'b0;
        w_cti = '0; w_bte = '0; h64_rdata = '0; h64_ready = 1'b1; h64_resp = 1'b0;
        for (int b = 0; b < 16; b++) wdata_tb[b] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_byte_write();
        test_incr_write();
        test_wrap_read();
        test_boundary();
        test_error();
        test_random_bursts();
        test_back_to_back();
        test_wide64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
